// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: AES/Rijndael ShiftRows (forward, inverse or bypass)
// applied as a beat enters a valid/ready pipeline of STAGES registers.
// The transform is done once on capture into stage 1; the remaining stages
// only hold and move data, so the mode travels implicitly with each beat.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic [1:0]          in_mode,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  localparam int W = 32 * NB;

  // Reject unsupported state widths and pipeline depths at elaboration.
  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: STAGES must be in 1..4");
    end
  endgenerate

  // Byte k of the state (column k/4, row k%4) lives at bits [W-1-8k -: 8].
  // Row r is rotated by C(r): 0,1,2,3 for NB 4/6 and 0,1,3,4 for NB 8.
  // Forward gathers from column c+C(r), inverse from column c-C(r).
  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d,
                                               input logic [1:0] mode);
    logic [W-1:0] res;
    int           off;
    int           src;
    res = d;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        off = (NB == 8 && r >= 2) ? r + 1 : r;
        if (mode == 2'b01) begin
          src = (c + off) % NB;
        end else begin
          src = (c - off + NB) % NB;
        end
        if (mode == 2'b01 || mode == 2'b10) begin
          res[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
        end
      end
    end
    return res;
  endfunction

  logic [STAGES-1:0] r_valid;
  logic [W-1:0]      r_data [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [STAGES-1:0] w_adv;
  logic [W-1:0]      w_xform;

  assign w_xform = shift_rows(in_data, in_mode);

  // Stage s advances if it is empty or stage s+1 advances. Unrolled, that is
  // "some stage from s to the end is empty, or downstream takes the beat",
  // which avoids a combinational chain through a single vector.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_adv
      assign w_adv[gi] = ~(&r_valid[STAGES-1:gi]) | out_ready;
    end
  endgenerate

  // Pipeline registers: stage 1 captures the transformed input, later stages
  // copy from their predecessor. Payload only loads with a valid beat so idle
  // input data never disturbs held contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_tag[s]   <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_xform;
          r_tag[0]  <= in_tag;
        end
      end
      for (int s = 1; s < STAGES; s++) begin
        if (w_adv[s]) begin
          r_valid[s] <= r_valid[s-1];
          if (r_valid[s-1]) begin
            r_data[s] <= r_data[s-1];
            r_tag[s]  <= r_tag[s-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign busy      = |r_valid;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Testbench for shift_rows_pipe: scoreboard-checked NB=4/STAGES=2 instance
// plus an NB=8/STAGES=3 instance for the wide-state round trip.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NB=4, STAGES=2 instance
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_data, a_out_data;
  logic [1:0]   a_in_mode;
  logic [3:0]   a_in_tag, a_out_tag;

  // NB=8, STAGES=3 instance
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [255:0] b_in_data, b_out_data;
  logic [1:0]   b_in_mode;
  logic [3:0]   b_in_tag, b_out_tag;

  shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .busy(a_busy)
  );

  shift_rows_pipe #(.NB(8), .STAGES(3), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .busy(b_busy)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   tag;
  } sb_t;

  sb_t sb_q[$];
  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_emit   = 0;
  logic         last_acc;
  logic         stall_seen = 1'b0;
  logic [127:0] stall_data;
  logic [3:0]   stall_tag;

  // Reference model: unpack into a row/column grid, then scatter (inverse)
  // or gather (forward) by row offset, then repack.
  function automatic logic [255:0] ref_rows(input logic [255:0] d,
                                            input logic [1:0] mode,
                                            input int nb);
    logic [7:0]   st [4][8];
    logic [7:0]   o  [4][8];
    int           off [4];
    logic [255:0] res;
    off[0] = 0; off[1] = 1;
    off[2] = (nb == 8) ? 3 : 2;
    off[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        o[r][c] = st[r][c];
    if (mode == 2'b01) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < nb; c++)
          o[r][c] = st[r][(c + off[r]) % nb];
    end else if (mode == 2'b10) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < nb; c++)
          o[r][(c + off[r]) % nb] = st[r][c];
    end
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        res[32*nb-1-8*(4*c+r) -: 8] = o[r][c];
    return res;
  endfunction

  // One clock of instance A with scoreboard bookkeeping; call at a negedge.
  task automatic tick_a();
    sb_t          e;
    logic [255:0] full;
    #1;
    if (a_out_valid && a_out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got tag=%0h data=%h, required no beat", a_out_tag, a_out_data);
      end else begin
        e = sb_q.pop_front();
        if (a_out_data !== e.data || a_out_tag !== e.tag) begin
          failures++;
          $display("FAIL sb_beat: got tag=%0h data=%h, required tag=%0h data=%h",
                   a_out_tag, a_out_data, e.tag, e.data);
        end
      end
      n_emit++;
    end
    if (stall_seen) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== stall_data || a_out_tag !== stall_tag) begin
        failures++;
        $display("FAIL stall_hold: got v=%b tag=%0h data=%h, required v=1 tag=%0h data=%h",
                 a_out_valid, a_out_tag, a_out_data, stall_tag, stall_data);
      end
    end
    stall_seen = a_out_valid && !a_out_ready;
    stall_data = a_out_data;
    stall_tag  = a_out_tag;
    last_acc = a_in_valid && a_in_ready;
    if (last_acc) begin
      full   = ref_rows({128'b0, a_in_data}, a_in_mode, 4);
      e.data = full[127:0];
      e.tag  = a_in_tag;
      sb_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 2'b00; a_in_tag = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 2'b00; b_in_tag = '0; b_out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_out_data !== '0 || a_out_tag !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b busy=%b data=%h tag=%0h, required all 0",
               a_out_valid, a_busy, a_out_data, a_out_tag);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", a_in_ready);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_out_data !== '0 || b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_nb8: got v=%b busy=%b rdy=%b, required v=0 busy=0 rdy=1",
               b_out_valid, b_busy, b_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    stall_seen = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed_nb4();
    logic [127:0] req [2];
    int lat;
    req[0] = 128'h00050A0F04090E03080D02070C01060B;
    req[1] = 128'h000D0A0704010E0B0805020F0C090603;
    for (int t = 0; t < 2; t++) begin
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 128'h000102030405060708090A0B0C0D0E0F;
      a_in_mode   = (t == 0) ? 2'b01 : 2'b10;
      a_in_tag    = 4'(5 + t);
      tick_a();
      checks++;
      if (last_acc !== 1'b1) begin
        failures++;
        $display("FAIL directed_accept[%0d]: got %b, required 1", t, last_acc);
      end
      a_in_valid = 1'b0;
      a_in_data  = {$urandom, $urandom, $urandom, $urandom};
      lat = 1;
      while (!a_out_valid && lat < 10) begin
        tick_a();
        lat++;
      end
      checks++;
      if (lat != 2) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d, required 2", t, lat);
      end
      checks++;
      if (a_out_data !== req[t]) begin
        failures++;
        $display("FAIL directed_data[%0d]: got %h, required %h", t, a_out_data, req[t]);
      end
      tick_a();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes [3];
    int idx, emit0, guard;
    modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b00;
    emit0 = n_emit;
    a_out_ready = 1'b0;
    idx = 0;
    a_in_valid = 1'b1;
    a_in_data  = {$urandom, $urandom, $urandom, $urandom};
    a_in_mode  = modes[0];
    a_in_tag   = 4'd1;
    for (int k = 0; k < 2; k++) begin
      tick_a();
      if (last_acc) begin
        idx++;
        a_in_data = {$urandom, $urandom, $urandom, $urandom};
        a_in_mode = modes[idx];
        a_in_tag  = 4'(idx + 1);
      end
    end
    #1;
    checks++;
    if (idx != 2 || a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_full: got accepts=%0d in_ready=%b busy=%b, required 2 0 1", idx, a_in_ready, a_busy);
    end
    tick_a();
    tick_a();
    a_out_ready = 1'b1;
    guard = 0;
    while (n_emit - emit0 < 3 && guard < 20) begin
      tick_a();
      if (last_acc && idx == 2) begin
        idx = 3;
        a_in_valid = 1'b0;
      end
      guard++;
    end
    checks++;
    if (n_emit - emit0 != 3 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: got emitted=%0d pending=%0d, required 3 0", n_emit - emit0, sb_q.size());
    end
  endtask

  task automatic test_toggle();
    int acc0, emit0, guard;
    acc0 = n_acc;
    emit0 = n_emit;
    a_in_valid = 1'b1;
    a_in_data  = {$urandom, $urandom, $urandom, $urandom};
    a_in_mode  = 2'($urandom_range(0, 3));
    a_in_tag   = 4'($urandom);
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_out_ready = (cyc % 2) == 0;
      tick_a();
      if (last_acc) begin
        a_in_data = {$urandom, $urandom, $urandom, $urandom};
        a_in_mode = 2'($urandom_range(0, 3));
        a_in_tag  = 4'($urandom);
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      tick_a();
      guard++;
    end
    checks++;
    if (sb_q.size() != 0 || (n_emit - emit0) != (n_acc - acc0) || (n_acc - acc0) < 20) begin
      failures++;
      $display("FAIL toggle_count: got acc=%0d emit=%0d pending=%0d, required acc>=20 emit=acc pending=0",
               n_acc - acc0, n_emit - emit0, sb_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int guard;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_in_data = {$urandom, $urandom, $urandom, $urandom};
      a_in_mode = 2'b01;
      a_in_tag  = 4'(8 + k);
      tick_a();
    end
    a_in_valid = 1'b0;
    #2;
    checks++;
    if (a_busy !== 1'b1 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midflight_loaded: got busy=%b v=%b, required 1 1", a_busy, a_out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== '0) begin
      failures++;
      $display("FAIL midflight_reset: got v=%b busy=%b rdy=%b data=%h, required 0 0 1 0",
               a_out_valid, a_busy, a_in_ready, a_out_data);
    end
    sb_q.delete();
    stall_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = {$urandom, $urandom, $urandom, $urandom};
    a_in_mode   = 2'b10;
    a_in_tag    = 4'hC;
    tick_a();
    a_in_valid = 1'b0;
    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      tick_a();
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL midflight_after: got pending=%0d, required 0", sb_q.size());
    end
  endtask

  // Pushes one beat through instance B and returns the output data.
  task automatic run_b(input logic [255:0] d, input logic [1:0] mode, output logic [255:0] q);
    int lat;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_mode  = mode;
    b_in_tag   = 4'hA;
    #1;
    checks++;
    if (b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL nb8_ready: got %b, required 1", b_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 3 || b_out_tag !== 4'hA) begin
      failures++;
      $display("FAIL nb8_latency: got lat=%0d tag=%0h, required lat=3 tag=a", lat, b_out_tag);
    end
    q = b_out_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_nb8();
    logic [255:0] orig, fwd, back, exp_fwd;
    orig = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    run_b(orig, 2'b01, fwd);
    exp_fwd = ref_rows(orig, 2'b01, 8);
    checks++;
    if (fwd !== exp_fwd) begin
      failures++;
      $display("FAIL nb8_forward: got %h, required %h", fwd, exp_fwd);
    end
    checks++;
    if (fwd[239 -: 8] !== 8'h0E || fwd[231 -: 8] !== 8'h13) begin
      failures++;
      $display("FAIL nb8_col0: got r2=%h r3=%h, required 0e 13", fwd[239 -: 8], fwd[231 -: 8]);
    end
    run_b(fwd, 2'b10, back);
    checks++;
    if (back !== orig) begin
      failures++;
      $display("FAIL nb8_roundtrip: got %h, required %h", back, orig);
    end
  endtask

  initial begin
    test_reset();
    test_directed_nb4();
    test_back_to_back();
    test_toggle();
    test_reset_midflight();
    test_nb8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4, meaning state columns; legal values 4, 6 and 8; any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline register stages; legal range 1..4; any other value SHALL fail elaboration.
REQ-003 The block SHALL have parameter TAG_W, default 4, meaning sideband tag width.
REQ-004 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Port in_valid  input  1  an input beat is offered.
REQ-007 Port in_ready  output  1  the block accepts the offered beat this cycle.
REQ-008 Port in_data  input  32*NB  state; byte k (column k/4, row k%4) at bits [32*NB-1-8k -: 8].
REQ-009 Port in_mode  input  2  00 bypass, 01 forward ShiftRows, 10 inverse ShiftRows, 11 bypass.
REQ-010 Port in_tag  input  TAG_W  opaque sideband carried with the beat.
REQ-011 Port out_valid  output  1  an output beat is presented.
REQ-012 Port out_ready  input  1  downstream accepts the presented beat.
REQ-013 Port out_data  output  32*NB  transformed state.
REQ-014 Port out_tag  output  TAG_W  tag of the presented beat.
REQ-015 Port busy  output  1  high when any stage holds a valid beat.

Function
REQ-016 Row offsets SHALL be C(0..3) = 0,1,2,3 for NB 4 or 6, and 0,1,3,4 for NB 8.
REQ-017 Forward mode SHALL compute out(r,c) = in(r,(c+C(r)) mod NB).
REQ-018 Inverse mode SHALL compute out(r,c) = in(r,(c-C(r)) mod NB).
REQ-019 Bypass mode SHALL pass in_data unchanged.
REQ-020 The transform SHALL be applied when a beat is captured into stage 1; later stages SHALL only hold and move data.
REQ-021 The mode SHALL be sampled per beat, so consecutive beats with different modes are each transformed by their own mode.
REQ-022 A beat SHALL be accepted when in_valid and in_ready are both high at a rising edge.
REQ-023 A beat SHALL leave when out_valid and out_ready are both high at a rising edge.
REQ-024 Each stage s SHALL hold valid_s, data_s and tag_s.
REQ-025 Stage s SHALL advance when valid_s is low or stage s+1 advances; for the last stage, "stage s+1 advances" means out_ready.
REQ-026 in_ready SHALL equal the stage-1 advance condition, computed combinationally from out_ready through the chain.
REQ-027 out_valid, out_data and out_tag SHALL be driven directly from the last stage.
REQ-028 Minimum latency SHALL be STAGES cycles from the accept edge to out_valid high.
REQ-029 With out_ready held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-030 With out_ready low, the pipeline SHALL fill to exactly STAGES beats; in_ready SHALL then go low.
REQ-031 While stalled, out_data and out_tag SHALL be held stable.
REQ-032 No beat SHALL be dropped, duplicated or reordered.
REQ-033 On simultaneous accept and emit while full, both SHALL occur in the same cycle and occupancy SHALL remain STAGES.
REQ-034 in_data, in_mode and in_tag SHALL be ignored whenever in_valid is low.
REQ-035 busy SHALL be the OR of all valid_s.

Reset
REQ-036 While rst is high, all valid_s SHALL be 0 and all data_s and tag_s SHALL be 0, regardless of clk.
REQ-037 During reset, out_valid=0, out_data=0, out_tag=0 and busy=0.
REQ-038 During reset, in_ready SHALL be 1 (it follows from REQ-026).
REQ-039 rst asserted mid-operation SHALL discard all in-flight beats immediately.
REQ-040 The first beat after rst deasserts SHALL be accepted normally.

Verification
REQ-041 Directed test: NB=4, forward, in_data=000102030405060708090A0B0C0D0E0F -> out_data=00050A0F04090E03080D02070C01060B after exactly STAGES cycles.
REQ-042 Directed test: NB=4, inverse, same input -> out_data=000D0A0704010E0B08050E0F0C090603 is wrong; required out_data=000D0A0704010E0B0805020F0C090603.
REQ-043 Directed test: NB=8 forward then inverse of bytes 00..1F -> the round trip returns the original; forward row 2 of column 0 = byte 0x0E, row 3 of column 0 = byte 0x13.
REQ-044 Directed test: STAGES=2, back-to-back beats with tags 1,2,3 and modes 01,10,00 while out_ready is low -> after 2 accepts in_ready=0; on raising out_ready, the outputs are tags 1,2,3 in order, each with its own mode applied.
REQ-045 Directed test: out_ready toggling 1/0 every cycle with continuous input -> no beats lost and data stable while stalled.
REQ-046 Directed test: assert rst with 2 beats in flight -> out_valid=0 and busy=0 immediately; a new beat after release emerges with correct data.
